// File: rtl/ase_hssi_mc_loopback.sv
// Multi-channel HSSI AXI-S loopback emulator for ASE.
// Each channel's TX stream goes into a FIFO with an accept timestamp. An RX FSM
// returns beats once they are LATENCY cycles old, on the same RX channel or on
// the partner channel. Pause is honoured only at packet boundaries, and each RX
// channel keeps saturating packet and beat statistics.
module ase_hssi_mc_loopback #(
  parameter int NUM_CHANNELS  = 4,
  parameter int TDATA_WIDTH   = 64,
  parameter int TUSER_WIDTH   = 10,
  parameter int TKEEP_WIDTH   = TDATA_WIDTH / 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int LATENCY       = 8,
  parameter int CROSS_CONNECT = 0
) (
  input  logic                                clk,
  input  logic                                SoftReset,
  input  logic [NUM_CHANNELS-1:0]             tx_tvalid,
  output logic [NUM_CHANNELS-1:0]             tx_tready,
  input  logic [NUM_CHANNELS-1:0]             tx_tlast,
  input  logic [NUM_CHANNELS*TDATA_WIDTH-1:0] tx_tdata,
  input  logic [NUM_CHANNELS*TKEEP_WIDTH-1:0] tx_tkeep,
  input  logic [NUM_CHANNELS*TUSER_WIDTH-1:0] tx_tuser,
  output logic [NUM_CHANNELS-1:0]             rx_tvalid,
  output logic [NUM_CHANNELS-1:0]             rx_tlast,
  output logic [NUM_CHANNELS*TDATA_WIDTH-1:0] rx_tdata,
  output logic [NUM_CHANNELS*TKEEP_WIDTH-1:0] rx_tkeep,
  output logic [NUM_CHANNELS*TUSER_WIDTH-1:0] rx_tuser,
  input  logic [NUM_CHANNELS-1:0]             tx_pause,
  output logic [NUM_CHANNELS-1:0]             rx_pause,
  output logic [NUM_CHANNELS*32-1:0]          pkt_count,
  output logic [NUM_CHANNELS*32-1:0]          beat_count
);

  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam int          CW    = AW + 1;
  localparam logic [15:0] LAT16 = 16'(LATENCY);

  typedef struct packed {
    logic                   last;
    logic [TKEEP_WIDTH-1:0] keep;
    logic [TUSER_WIDTH-1:0] user;
    logic [TDATA_WIDTH-1:0] data;
    logic [15:0]            ts;
  } entry_t;

  typedef enum logic {ST_IDLE, ST_IN_PKT} rx_state_e;

  logic [15:0]             now_q;
  logic [NUM_CHANNELS-1:0] push;
  logic [NUM_CHANNELS-1:0] pop;
  logic [NUM_CHANNELS-1:0] emit;
  logic [NUM_CHANNELS-1:0] head_elig;
  entry_t                  head [NUM_CHANNELS];

  // Free-running timestamp. Ages are computed modulo 2^16, so the wrap is harmless.
  always_ff @(posedge clk or posedge SoftReset) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (SoftReset) now_q <= '0;
    else           now_q <= now_q + 16'd1;
  end

  // Pause mirror toward the AFU, delayed by one cycle.
  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) rx_pause <= '0;
    else           rx_pause <= tx_pause;
  end

  // Per-channel timestamped FIFO. It is indexed by the TX channel.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_fifo
    localparam int DST = (CROSS_CONNECT != 0) ? (c ^ 1) : c;

    entry_t        mem [FIFO_DEPTH];
    entry_t        wr_entry;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          tready_q;
    logic [15:0]   age;

    assign push[c]      = tx_tvalid[c] & tready_q;
    assign pop[c]       = emit[DST];
    assign tx_tready[c] = tready_q;
    assign wr_entry     = {tx_tlast[c],
                           tx_tkeep[c*TKEEP_WIDTH +: TKEEP_WIDTH],
                           tx_tuser[c*TUSER_WIDTH +: TUSER_WIDTH],
                           tx_tdata[c*TDATA_WIDTH +: TDATA_WIDTH],
                           now_q};

    // Beat storage write.
    always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset. Validity comes from the reset pointers and the count.
      if (push[c]) mem[wr_ptr_q] <= wr_entry;
    end

    // Occupancy next state. A push and a pop in the same cycle leave the count unchanged.
    always_comb begin
      // NOTE: the default assignment comes first, so no path through this block can infer a latch.
      count_d = count_q;
      if (push[c] && !pop[c])      count_d = count_q + CW'(1);
      else if (!push[c] && pop[c]) count_d = count_q - CW'(1);
    end

    // Pointers, occupancy and registered ready. Ready keeps one slot free for the beat accepted this cycle.
    always_ff @(posedge clk or posedge SoftReset) begin
      if (SoftReset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        tready_q <= 1'b0;
      end else begin
        if (push[c]) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop[c])  rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q  <= count_d;
        tready_q <= (count_d <= CW'(FIFO_DEPTH - 2));
      end
    end

    assign head[c]      = mem[rd_ptr_q];
    assign age          = now_q - head[c].ts;
    assign head_elig[c] = (count_q != '0) && (age >= LAT16);

    // A write into a full FIFO means the AFU ignored tready.
    a_no_overflow: assert property (@(posedge clk) disable iff (SoftReset)
                                    !(push[c] && (count_q == CW'(FIFO_DEPTH))));
  end

  // Per-RX-channel emit logic. Channel r drains FIFO r, or FIFO r^1 in cross mode.
  for (genvar r = 0; r < NUM_CHANNELS; r++) begin : g_rx
    localparam int SRC = (CROSS_CONNECT != 0) ? (r ^ 1) : r;

    rx_state_e              state_q;
    logic                   valid_q;
    logic                   last_q;
    logic [TDATA_WIDTH-1:0] data_q;
    logic [TKEEP_WIDTH-1:0] keep_q;
    logic [TUSER_WIDTH-1:0] user_q;
    logic [31:0]            pkt_q;
    logic [31:0]            beat_q;

    // Pause can only hold back the first beat of a packet.
    assign emit[r] = head_elig[SRC] && ((state_q == ST_IN_PKT) || !tx_pause[r]);

    // Packet-boundary FSM with a registered RX beat and saturating statistics.
    always_ff @(posedge clk or posedge SoftReset) begin
      if (SoftReset) begin
        state_q <= ST_IDLE;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        data_q  <= '0;
        keep_q  <= '0;
        user_q  <= '0;
        pkt_q   <= '0;
        beat_q  <= '0;
      end else begin
        valid_q <= emit[r];
        if (emit[r]) begin
          last_q  <= head[SRC].last;
          data_q  <= head[SRC].data;
          keep_q  <= head[SRC].keep;
          user_q  <= head[SRC].user;
          state_q <= head[SRC].last ? ST_IDLE : ST_IN_PKT;
          if (beat_q != '1)                   beat_q <= beat_q + 32'd1;
          if (head[SRC].last && (pkt_q != '1)) pkt_q  <= pkt_q + 32'd1;
        end
      end
    end

    assign rx_tvalid[r]                           = valid_q;
    assign rx_tlast[r]                            = last_q;
    assign rx_tdata[r*TDATA_WIDTH +: TDATA_WIDTH] = data_q;
    assign rx_tkeep[r*TKEEP_WIDTH +: TKEEP_WIDTH] = keep_q;
    assign rx_tuser[r*TUSER_WIDTH +: TUSER_WIDTH] = user_q;
    assign pkt_count[r*32 +: 32]                  = pkt_q;
    assign beat_count[r*32 +: 32]                 = beat_q;
  end

endmodule

// File: tb/tb_ase_hssi_mc_loopback.sv
// Bench for ase_hssi_mc_loopback.
// dut_a uses the defaults (LATENCY=8, straight mapping). dut_b uses LATENCY=32 with cross mapping.
// The checks are a table-driven single packet, hand-written cross/pause/back-pressure/reset
// sequences, and a long randomized run that crosses the 16-bit timestamp wrap.
module tb_ase_hssi_mc_loopback;
  localparam int N           = 4;
  localparam int DW          = 64;
  localparam int UW          = 10;
  localparam int KW          = DW / 8;
  localparam int DEPTH       = 16;
  localparam int LAT_A       = 8;
  localparam int LAT_B       = 32;
  localparam int RAND_CYCLES = 66_000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_a, rst_b;
  logic [N-1:0]    a_tx_valid, a_tx_ready, a_tx_last, a_rx_valid, a_rx_last, a_tx_pause, a_rx_pause;
  logic [N*DW-1:0] a_tx_data, a_rx_data;
  logic [N*KW-1:0] a_tx_keep, a_rx_keep;
  logic [N*UW-1:0] a_tx_user, a_rx_user;
  logic [N*32-1:0] a_pkt, a_beat;
  logic [N-1:0]    b_tx_valid, b_tx_ready, b_tx_last, b_rx_valid, b_rx_last, b_tx_pause, b_rx_pause;
  logic [N*DW-1:0] b_tx_data, b_rx_data;
  logic [N*KW-1:0] b_tx_keep, b_rx_keep;
  logic [N*UW-1:0] b_tx_user, b_rx_user;
  logic [N*32-1:0] b_pkt, b_beat;

  ase_hssi_mc_loopback #(.NUM_CHANNELS(N), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .TKEEP_WIDTH(KW),
                         .FIFO_DEPTH(DEPTH), .LATENCY(LAT_A), .CROSS_CONNECT(0)) dut_a (
    .clk(clk), .SoftReset(rst_a),
    .tx_tvalid(a_tx_valid), .tx_tready(a_tx_ready), .tx_tlast(a_tx_last),
    .tx_tdata(a_tx_data), .tx_tkeep(a_tx_keep), .tx_tuser(a_tx_user),
    .rx_tvalid(a_rx_valid), .rx_tlast(a_rx_last), .rx_tdata(a_rx_data),
    .rx_tkeep(a_rx_keep), .rx_tuser(a_rx_user),
    .tx_pause(a_tx_pause), .rx_pause(a_rx_pause),
    .pkt_count(a_pkt), .beat_count(a_beat));

  ase_hssi_mc_loopback #(.NUM_CHANNELS(N), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .TKEEP_WIDTH(KW),
                         .FIFO_DEPTH(DEPTH), .LATENCY(LAT_B), .CROSS_CONNECT(1)) dut_b (
    .clk(clk), .SoftReset(rst_b),
    .tx_tvalid(b_tx_valid), .tx_tready(b_tx_ready), .tx_tlast(b_tx_last),
    .tx_tdata(b_tx_data), .tx_tkeep(b_tx_keep), .tx_tuser(b_tx_user),
    .rx_tvalid(b_rx_valid), .rx_tlast(b_rx_last), .rx_tdata(b_rx_data),
    .rx_tkeep(b_rx_keep), .rx_tuser(b_rx_user),
    .tx_pause(b_tx_pause), .rx_pause(b_rx_pause),
    .pkt_count(b_pkt), .beat_count(b_beat));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat_data(input int tag);
    return 64'hC0DE_0000_0000_0000 | 64'(tag);
  endfunction

  task automatic a_set(input int c, input logic v, input logic l, input logic [63:0] d);
    a_tx_valid[c]          = v;
    a_tx_last[c]           = l;
    a_tx_data[c*DW +: DW]  = d;
    a_tx_keep[c*KW +: KW]  = d[7:0];
    a_tx_user[c*UW +: UW]  = d[17:8];
  endtask

  task automatic b_set(input int c, input logic v, input logic l, input logic [63:0] d);
    b_tx_valid[c]          = v;
    b_tx_last[c]           = l;
    b_tx_data[c*DW +: DW]  = d;
    b_tx_keep[c*KW +: KW]  = d[7:0];
    b_tx_user[c*UW +: UW]  = d[17:8];
  endtask

  // Table record: ch0 TX inputs in one cycle and the ch0 RX result expected in that same cycle.
  typedef struct {
    logic        in_v;
    logic        in_l;
    logic [63:0] in_d;
    logic        exp_v;
    logic        exp_l;
    logic [63:0] exp_d;
  } vec_t;
  vec_t vt [16];

  // Reference model: one queue per channel, and each beat carries its accept cycle.
  typedef struct {
    logic [63:0]   d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
    int            acc;
  } mbeat_t;
  mbeat_t       mq [N][$];
  mbeat_t       exp_b [N];
  logic [N-1:0] exp_v = '0;
  bit           in_pkt [N];
  int           m_pkts [N];
  int           m_beats [N];

  // Compare this cycle's RX outputs against the prediction made in the previous cycle.
  task automatic rand_compare();
    for (int r = 0; r < N; r++) begin
      check($sformatf("rnd_valid[%0d]", r), 64'(a_rx_valid[r]), 64'(exp_v[r]));
      if (exp_v[r]) begin
        check($sformatf("rnd_data[%0d]", r), a_rx_data[r*DW +: DW], exp_b[r].d);
        check($sformatf("rnd_keep[%0d]", r), 64'(a_rx_keep[r*KW +: KW]), 64'(exp_b[r].k));
        check($sformatf("rnd_user[%0d]", r), 64'(a_rx_user[r*UW +: UW]), 64'(exp_b[r].u));
        check($sformatf("rnd_last[%0d]", r), 64'(a_rx_last[r]), 64'(exp_b[r].l));
      end
    end
  endtask

  // Predict the next cycle's RX outputs. A beat accepted in cycle A may leave once A+LATENCY has
  // been reached, in FIFO order, and pause can only block the first beat of a packet.
  task automatic model_step(input int k);
    for (int r = 0; r < N; r++) begin
      exp_v[r] = 1'b0;
      if (mq[r].size() > 0 && (mq[r][0].acc + LAT_A <= k) && (in_pkt[r] || !a_tx_pause[r])) begin
        exp_b[r] = mq[r].pop_front();
        exp_v[r] = 1'b1;
        in_pkt[r] = !exp_b[r].l;
        m_beats[r]++;
        if (exp_b[r].l) m_pkts[r]++;
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int          sent, got, first_drop, drained;
    logic [N-1:0] stray;
    mbeat_t      nb;

    rst_a = 1'b1; rst_b = 1'b1;
    a_tx_valid = '0; a_tx_last = '0; a_tx_data = '0; a_tx_keep = '0; a_tx_user = '0; a_tx_pause = '0;
    b_tx_valid = '0; b_tx_last = '0; b_tx_data = '0; b_tx_keep = '0; b_tx_user = '0; b_tx_pause = '0;
    repeat (3) tick();

    // Reset state.
    check("rst_rx_valid", 64'(a_rx_valid), 64'd0);
    check("rst_tready",   64'(a_tx_ready), 64'd0);
    check("rst_rx_data",  a_rx_data[63:0], 64'd0);
    check("rst_rx_pause", 64'(a_rx_pause), 64'd0);
    for (int c = 0; c < N; c++) begin
      check($sformatf("rst_pkt[%0d]", c),  64'(a_pkt[c*32 +: 32]),  64'd0);
      check($sformatf("rst_beat[%0d]", c), 64'(a_beat[c*32 +: 32]), 64'd0);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    tick(); tick();
    check("ready_after_rst", 64'(a_tx_ready), 64'hF);

    // Test 1: a 3-beat packet on ch0 returns LATENCY+1 cycles later (table driven).
    for (int i = 0; i < 16; i++) vt[i] = '{default: 0};
    for (int i = 0; i < 3; i++) begin
      vt[i].in_v = 1'b1;
      vt[i].in_l = (i == 2);
      vt[i].in_d = beat_data(16'h100 + i);
      vt[i + LAT_A + 1].exp_v = 1'b1;
      vt[i + LAT_A + 1].exp_l = (i == 2);
      vt[i + LAT_A + 1].exp_d = beat_data(16'h100 + i);
    end
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t1_valid[%0d]", i), 64'(a_rx_valid), 64'({3'b000, vt[i].exp_v}));
      if (vt[i].exp_v) begin
        check($sformatf("t1_data[%0d]", i), a_rx_data[DW-1:0], vt[i].exp_d);
        check($sformatf("t1_last[%0d]", i), 64'(a_rx_last[0]), 64'(vt[i].exp_l));
        check($sformatf("t1_keep[%0d]", i), 64'(a_rx_keep[KW-1:0]), 64'(vt[i].exp_d[7:0]));
      end
      if (vt[i].in_v) check($sformatf("t1_tready[%0d]", i), 64'(a_tx_ready[0]), 64'd1);
      a_set(0, vt[i].in_v, vt[i].in_l, vt[i].in_d);
      tick();
    end
    a_set(0, 1'b0, 1'b0, 64'd0);
    tick(); tick();
    check("t1_pkt0",  64'(a_pkt[31:0]),  64'd1);
    check("t1_beat0", 64'(a_beat[31:0]), 64'd3);
    check("t1_beat1", 64'(a_beat[63:32]), 64'd0);

    // Test 2: in cross mode, TX ch2 comes back only on RX ch3.
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] ev;
      ev = (i == LAT_B + 1 || i == LAT_B + 2) ? 4'b1000 : 4'b0000;
      check($sformatf("t2_valid[%0d]", i), 64'(b_rx_valid), 64'(ev));
      if (ev[3]) check($sformatf("t2_data[%0d]", i), b_rx_data[3*DW +: DW], beat_data(16'h200 + i - LAT_B - 1));
      b_set(2, i < 2, i == 1, beat_data(16'h200 + i));
      tick();
    end
    b_set(2, 1'b0, 1'b0, 64'd0);
    check("t2_pkt3", 64'(b_pkt[3*32 +: 32]), 64'd1);
    check("t2_pkt2", 64'(b_pkt[2*32 +: 32]), 64'd0);

    // Test 3: pause holds ch1 at the packet boundary. Pause is low only in cycle 20, and
    // raising it again mid-packet does not stop the rest of the packet.
    for (int i = 0; i < 32; i++) begin
      logic ev;
      ev = (i >= 21 && i <= 24);
      check($sformatf("t3_valid[%0d]", i), 64'(a_rx_valid), 64'({2'b00, ev, 1'b0}));
      if (ev) begin
        check($sformatf("t3_data[%0d]", i), a_rx_data[DW +: DW], beat_data(16'h300 + i - 21));
        check($sformatf("t3_last[%0d]", i), 64'(a_rx_last[1]), 64'(i == 24));
      end
      if (i > 0) check($sformatf("t3_rx_pause[%0d]", i), 64'(a_rx_pause[1]), 64'((i - 1) != 20));
      a_tx_pause[1] = (i != 20);
      a_set(1, i < 4, i == 3, beat_data(16'h300 + i));
      tick();
    end
    a_tx_pause[1] = 1'b0;
    a_set(1, 1'b0, 1'b0, 64'd0);
    check("t3_pkt1",  64'(a_pkt[63:32]),  64'd1);
    check("t3_beat1", 64'(a_beat[63:32]), 64'd4);

    // Test 4: 20 back-to-back beats, depth 16 and latency 32. Ready drops after 15 accepts and order is kept.
    sent = 0; got = 0; first_drop = -1; stray = '0;
    for (int i = 0; i < 400 && got < 20; i++) begin
      stray |= b_rx_valid & 4'b1101;
      if (b_rx_valid[1]) begin
        check($sformatf("t4_order[%0d]", got), b_rx_data[DW +: DW], beat_data(16'h400 + got));
        got++;
      end
      if (sent < 20) begin
        if (!b_tx_ready[0] && first_drop < 0) first_drop = sent;
        b_set(0, 1'b1, (sent % 10) == 9, beat_data(16'h400 + sent));
        if (b_tx_ready[0]) sent++;
      end else begin
        b_set(0, 1'b0, 1'b0, 64'd0);
      end
      tick();
    end
    b_set(0, 1'b0, 1'b0, 64'd0);
    check("t4_received",    64'(got),        64'd20);
    check("t4_tready_drop", 64'(first_drop), 64'd15);
    check("t4_stray",       64'(stray),      64'd0);

    // Test 5: a SoftReset pulse in the middle of a ch0 packet. Afterwards the FSM must restart in IDLE,
    // which the new packet shows by waiting for pause to drop.
    for (int i = 0; i < 11; i++) begin
      a_set(0, i < 4, i == 3, beat_data(16'h500 + i));
      tick();
    end
    check("t5_mid_valid", 64'(a_rx_valid[0]), 64'd1);
    check("t5_mid_pkt0",  64'(a_pkt[31:0]),   64'd1);
    a_set(0, 1'b0, 1'b0, 64'd0);
    #2 rst_a = 1'b1;
    #1;
    check("t5_rst_valid", 64'(a_rx_valid), 64'd0);
    for (int c = 0; c < N; c++) begin
      check($sformatf("t5_rst_pkt[%0d]", c),  64'(a_pkt[c*32 +: 32]),  64'd0);
      check($sformatf("t5_rst_beat[%0d]", c), 64'(a_beat[c*32 +: 32]), 64'd0);
    end
    tick();
    rst_a = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      logic ev;
      ev = (i == 13 || i == 14);
      check($sformatf("t5_valid[%0d]", i), 64'(a_rx_valid), 64'({3'b000, ev}));
      if (ev) check($sformatf("t5_data[%0d]", i), a_rx_data[DW-1:0], beat_data(16'h580 + i - 13));
      a_tx_pause[0] = (i < 12);
      a_set(0, i < 2, i == 1, beat_data(16'h580 + i));
      tick();
    end
    a_tx_pause[0] = 1'b0;
    a_set(0, 1'b0, 1'b0, 64'd0);
    check("t5_pkt0",  64'(a_pkt[31:0]),  64'd1);
    check("t5_beat0", 64'(a_beat[31:0]), 64'd2);

    // Test 6: randomized traffic and pause on dut_a, checked against the queue model.
    // The run is long enough to carry the 16-bit timestamp through its wrap.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    tick();
    for (int r = 0; r < N; r++) begin
      in_pkt[r] = 1'b0; m_pkts[r] = 0; m_beats[r] = 0;
    end
    exp_v = '0;
    for (int k = 0; k < RAND_CYCLES && bad < 100; k++) begin
      rand_compare();
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 49) == 0) a_tx_pause[c] = ~a_tx_pause[c];
        if (a_tx_ready[c] && $urandom_range(0, 99) < 45) begin
          nb.d = {$urandom, $urandom};
          nb.k = KW'($urandom);
          nb.u = UW'($urandom);
          nb.l = ($urandom_range(0, 3) == 0);
          nb.acc = k;
          a_tx_valid[c] = 1'b1;
          a_tx_last[c]  = nb.l;
          a_tx_data[c*DW +: DW] = nb.d;
          a_tx_keep[c*KW +: KW] = nb.k;
          a_tx_user[c*UW +: UW] = nb.u;
          mq[c].push_back(nb);
        end else begin
          a_tx_valid[c] = 1'b0;
        end
      end
      model_step(k);
      tick();
    end
    a_tx_valid = '0;
    a_tx_pause = '0;
    drained = 0;
    for (int k = RAND_CYCLES; k < RAND_CYCLES + 500; k++) begin
      rand_compare();
      if (exp_v == '0 && mq[0].size() == 0 && mq[1].size() == 0 &&
          mq[2].size() == 0 && mq[3].size() == 0) begin
        drained = 1;
        break;
      end
      model_step(k);
      tick();
    end
    check("rnd_drained", 64'(drained), 64'd1);
    tick();
    for (int r = 0; r < N; r++) begin
      check($sformatf("rnd_pkt[%0d]", r),  64'(a_pkt[r*32 +: 32]),  64'(m_pkts[r]));
      check($sformatf("rnd_beat[%0d]", r), 64'(a_beat[r*32 +: 32]), 64'(m_beats[r]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
